// File: rtl/fetch_decode_reg_pkg.sv
// Shared instruction-format constants for the fetch/decode boundary and control.
// Opcode values, field bit positions and small classification helpers.
package fetch_decode_reg_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam int INSTR_W  = 32;
    localparam int PC_W     = 32;

    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = 6;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int REG_W      = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int FUNCT_W    = 6;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = 16;
    localparam int TARGET_LSB = 0;
    localparam int TARGET_W   = 26;

    typedef struct packed {
        logic             valid;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    function automatic logic is_rtype_op(input logic [OPCODE_W-1:0] op);
        return op == OP_RTYPE;
    endfunction

    function automatic logic is_jtype_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/fd_entry_reg.sv
// One pipeline entry (valid + instruction + pc) with load and clear; clear wins.
// Payload only moves on load, so an invalid entry keeps stale data that the top masks.
import fetch_decode_reg_pkg::*;

module fd_entry_reg (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [PC_W-1:0]    d_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= '0;
            pc    <= '0;
        end else if (load && !clear) begin
            instr <= d_instr;
            pc    <= d_pc;
        end
    end

endmodule

// File: rtl/fetch_decode_reg.sv
// Fetch-to-decode skid register: 1-cycle latency, one word/cycle sustained.
// o_ready comes straight from the skid valid flop, so it never depends on i_ready.
import fetch_decode_reg_pkg::*;

module fetch_decode_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_shamt,
    output logic [5:0]  o_funct,
    output logic [15:0] o_imm,
    output logic [25:0] o_target,
    output logic [31:0] o_pc_plus4,
    output logic        o_is_rtype,
    output logic        o_is_jtype
);

    entry_t head;
    entry_t skid;

    logic               accept;
    logic               consume;
    logic               head_free;
    logic               head_load;
    logic               head_clear;
    logic               skid_load;
    logic               skid_clear;
    logic [INSTR_W-1:0] head_d_instr;
    logic [PC_W-1:0]    head_d_pc;
    logic [OPCODE_W-1:0] head_op;

    assign o_ready   = !skid.valid;
    assign accept    = i_valid && o_ready;
    assign consume   = head.valid && i_ready;
    assign head_free = !head.valid || consume;

    // A full skid always refills HEAD first; while it is full o_ready is low,
    // so an incoming word can never race it for HEAD.
    always_comb begin
        head_load    = 1'b0;
        skid_load    = 1'b0;
        head_d_instr = i_instr;
        head_d_pc    = i_pc;
        if (!i_flush) begin
            if (skid.valid) begin
                head_load    = consume;
                head_d_instr = skid.instr;
                head_d_pc    = skid.pc;
            end else if (accept) begin
                head_load = head_free;
                skid_load = !head_free;
            end
        end
    end

    assign head_clear = i_flush || (consume && !head_load);
    assign skid_clear = i_flush || (skid.valid && consume);

    fd_entry_reg u_head (
        .clk     (i_clk),
        .rst     (i_rst),
        .load    (head_load),
        .clear   (head_clear),
        .d_instr (head_d_instr),
        .d_pc    (head_d_pc),
        .valid   (head.valid),
        .instr   (head.instr),
        .pc      (head.pc)
    );

    fd_entry_reg u_skid (
        .clk     (i_clk),
        .rst     (i_rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_instr (i_instr),
        .d_pc    (i_pc),
        .valid   (skid.valid),
        .instr   (skid.instr),
        .pc      (skid.pc)
    );

    // Decode view of HEAD; everything reads as zero / RESET_PC while HEAD is empty.
    assign head_op = head.instr[OPCODE_LSB +: OPCODE_W];

    always_comb begin
        o_valid    = head.valid;
        o_opcode   = '0;
        o_rs       = '0;
        o_rt       = '0;
        o_rd       = '0;
        o_shamt    = '0;
        o_funct    = '0;
        o_imm      = '0;
        o_target   = '0;
        o_pc_plus4 = RESET_PC;
        o_is_rtype = 1'b0;
        o_is_jtype = 1'b0;
        if (head.valid) begin
            o_opcode   = head_op;
            o_rs       = head.instr[RS_LSB    +: REG_W];
            o_rt       = head.instr[RT_LSB    +: REG_W];
            o_rd       = head.instr[RD_LSB    +: REG_W];
            o_shamt    = head.instr[SHAMT_LSB +: REG_W];
            o_funct    = head.instr[FUNCT_LSB +: FUNCT_W];
            o_imm      = head.instr[IMM_LSB   +: IMM_W];
            o_target   = head.instr[TARGET_LSB +: TARGET_W];
            o_pc_plus4 = head.pc + 32'd4;
            o_is_rtype = is_rtype_op(head_op);
            o_is_jtype = is_jtype_op(head_op);
        end
    end

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed bench for fetch_decode_reg: hand-computed expectations per scenario.
module tb_fetch_decode_reg;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [5:0]  o_opcode;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [5:0]  o_funct;
    logic [15:0] o_imm;
    logic [25:0] o_target;
    logic [31:0] o_pc_plus4;
    logic        o_is_rtype, o_is_jtype;

    int vectors = 0;
    int miscompares = 0;

    fetch_decode_reg #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_opcode(o_opcode), .o_rs(o_rs), .o_rt(o_rt),
        .o_rd(o_rd), .o_shamt(o_shamt), .o_funct(o_funct), .o_imm(o_imm),
        .o_target(o_target), .o_pc_plus4(o_pc_plus4),
        .o_is_rtype(o_is_rtype), .o_is_jtype(o_is_jtype)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        i_valid = v;
        i_instr = ins;
        i_pc    = pc;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        #2;
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", o_valid); end
        vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", o_ready); end
        vectors++; if (o_imm !== 16'h0) begin miscompares++; $display("FAIL reset_imm got %h want 0", o_imm); end
        vectors++; if (o_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL reset_pc4 got %h want 0", o_pc_plus4); end
        tick(); tick();
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        i_ready = 1'b1;
        offer(1'b1, 32'h2008_800F, 32'h0000_0040);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", o_valid); end
        vectors++; if (o_opcode !== 6'h08) begin miscompares++; $display("FAIL single_opcode got %h want 08", o_opcode); end
        vectors++; if (o_rs !== 5'd0) begin miscompares++; $display("FAIL single_rs got %0d want 0", o_rs); end
        vectors++; if (o_rt !== 5'd8) begin miscompares++; $display("FAIL single_rt got %0d want 8", o_rt); end
        vectors++; if (o_imm !== 16'h800F) begin miscompares++; $display("FAIL single_imm got %h want 800f", o_imm); end
        vectors++; if (o_pc_plus4 !== 32'h0000_0044) begin miscompares++; $display("FAIL single_pc4 got %h want 44", o_pc_plus4); end
        vectors++; if (o_is_rtype !== 1'b0 || o_is_jtype !== 1'b0) begin miscompares++; $display("FAIL single_flags got r%b j%b want r0 j0", o_is_rtype, o_is_jtype); end
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b want 0", o_valid); end
        vectors++; if (o_pc_plus4 !== 32'h0 || o_opcode !== 6'h0) begin miscompares++; $display("FAIL single_empty got pc4 %h op %h want 0 0", o_pc_plus4, o_opcode); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [4];
        logic [15:0] imm_exp [4];
        logic [31:0] pc4_exp [4];
        w = '{32'h0000_0000, 32'h012A_4020, 32'h8C88_0004, 32'h0800_0100};
        imm_exp = '{16'h0000, 16'h4020, 16'h0004, 16'h0100};
        pc4_exp = '{32'h0000_0104, 32'h0000_0108, 32'h0000_010C, 32'h0000_0110};
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d] got %b want 1", k, o_ready); end
            offer(1'b1, w[k], 32'h0000_0100 + 32'(k) * 4);
            tick();
            vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d] got %b want 1", k, o_valid); end
            vectors++; if (o_imm !== imm_exp[k]) begin miscompares++; $display("FAIL b2b_imm[%0d] got %h want %h", k, o_imm, imm_exp[k]); end
            vectors++; if (o_pc_plus4 !== pc4_exp[k]) begin miscompares++; $display("FAIL b2b_pc4[%0d] got %h want %h", k, o_pc_plus4, pc4_exp[k]); end
        end
        offer(1'b0, 32'h0, 32'h0);
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", o_valid); end
    endtask

    task automatic test_stall();
        i_ready = 1'b0;
        offer(1'b1, 32'h2001_1111, 32'h0000_0200);
        tick();
        vectors++; if (o_ready !== 1'b1 || o_rt !== 5'd1) begin miscompares++; $display("FAIL stall_w1 got rdy %b rt %0d want 1 1", o_ready, o_rt); end
        offer(1'b1, 32'h2002_2222, 32'h0000_0204);
        tick();
        vectors++; if (o_ready !== 1'b0 || o_rt !== 5'd1) begin miscompares++; $display("FAIL stall_w2 got rdy %b rt %0d want 0 1", o_ready, o_rt); end
        offer(1'b1, 32'h2003_3333, 32'h0000_0208);
        tick();
        vectors++; if (o_ready !== 1'b0 || o_imm !== 16'h1111) begin miscompares++; $display("FAIL stall_hold got rdy %b imm %h want 0 1111", o_ready, o_imm); end
        i_ready = 1'b1;
        tick();
        vectors++; if (o_valid !== 1'b1 || o_imm !== 16'h2222 || o_pc_plus4 !== 32'h208) begin miscompares++; $display("FAIL stall_out2 got v%b imm %h pc4 %h want 1 2222 208", o_valid, o_imm, o_pc_plus4); end
        vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL stall_reopen got %b want 1", o_ready); end
        tick();
        offer(1'b0, 32'h0, 32'h0);
        vectors++; if (o_valid !== 1'b1 || o_imm !== 16'h3333 || o_pc_plus4 !== 32'h20C) begin miscompares++; $display("FAIL stall_out3 got v%b imm %h pc4 %h want 1 3333 20c", o_valid, o_imm, o_pc_plus4); end
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain got %b want 0", o_valid); end
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        offer(1'b1, 32'h2001_AAAA, 32'h0000_0300); tick();
        offer(1'b1, 32'h2002_BBBB, 32'h0000_0304); tick();
        offer(1'b1, 32'h2003_CCCC, 32'h0000_0308);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        vectors++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin miscompares++; $display("FAIL flush_full got v%b r%b want 0 1", o_valid, o_ready); end
        i_ready = 1'b1;
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL flush_noleak got %b want 0", o_valid); end
        i_ready = 1'b0;
        offer(1'b1, 32'h2004_DDDD, 32'h0000_0400); tick();
        offer(1'b1, 32'h2005_EEEE, 32'h0000_0404);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        vectors++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin miscompares++; $display("FAIL flush_drop got v%b r%b want 0 1", o_valid, o_ready); end
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drop2 got %b want 0", o_valid); end
    endtask

    task automatic test_async_reset();
        i_ready = 1'b0;
        offer(1'b1, 32'h2008_1234, 32'h0000_0500);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre got %b want 1", o_valid); end
        #2 i_rst = 1'b1;
        #1;
        vectors++; if (o_valid !== 1'b0 || o_imm !== 16'h0) begin miscompares++; $display("FAIL arst_imm got v%b imm %h want 0 0", o_valid, o_imm); end
        vectors++; if (o_ready !== 1'b1 || o_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL arst_ready got r%b pc4 %h want 1 0", o_ready, o_pc_plus4); end
        offer(1'b1, 32'h2009_5678, 32'h0000_0600);
        tick();
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL arst_hold got %b want 0", o_valid); end
        #2 i_rst = 1'b0;
        tick();
        offer(1'b0, 32'h0, 32'h0);
        vectors++; if (o_valid !== 1'b1 || o_imm !== 16'h5678) begin miscompares++; $display("FAIL arst_release got v%b imm %h want 1 5678", o_valid, o_imm); end
        i_ready = 1'b1;
        tick();
    endtask

    task automatic test_type_flags();
        i_ready = 1'b1;
        offer(1'b1, 32'h012A_4020, 32'h0000_0700);
        tick();
        vectors++; if (o_is_rtype !== 1'b1 || o_is_jtype !== 1'b0) begin miscompares++; $display("FAIL rtype_flags got r%b j%b want 1 0", o_is_rtype, o_is_jtype); end
        vectors++; if (o_rs !== 5'd9 || o_rt !== 5'd10 || o_rd !== 5'd8 || o_shamt !== 5'd0 || o_funct !== 6'h20) begin miscompares++; $display("FAIL rtype_fields got %0d %0d %0d %0d %h want 9 10 8 0 20", o_rs, o_rt, o_rd, o_shamt, o_funct); end
        offer(1'b1, 32'h0C00_0010, 32'hFFFF_FFFC);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        vectors++; if (o_is_jtype !== 1'b1 || o_is_rtype !== 1'b0) begin miscompares++; $display("FAIL jal_flags got r%b j%b want 0 1", o_is_rtype, o_is_jtype); end
        vectors++; if (o_target !== 26'h10 || o_opcode !== 6'h03) begin miscompares++; $display("FAIL jal_target got %h op %h want 10 03", o_target, o_opcode); end
        vectors++; if (o_pc_plus4 !== 32'h0000_0000 || o_valid !== 1'b1) begin miscompares++; $display("FAIL jal_wrap got pc4 %h v%b want 0 1", o_pc_plus4, o_valid); end
        tick();
        vectors++; if (o_valid !== 1'b0 || o_is_jtype !== 1'b0) begin miscompares++; $display("FAIL flags_gated got v%b j%b want 0 0", o_valid, o_is_jtype); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        test_type_flags();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
